// File: rtl/multi_square_object_pkg.sv
// Shared constants and object state for multi_square_object.
// Object coordinates are stored at OBJ_COORD_W bits so one struct serves any COORD_W up to 16.
package multi_square_object_pkg;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
  localparam int         OBJ_COORD_W          = 16;

  // No entry may equal TRANSPARENT_ENCODING, or a hit would be invisible downstream.
  localparam logic [7:0] COLOR_TABLE [16] = '{
    8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'h92, 8'h49,
    8'hB6, 8'h6D, 8'hF0, 8'h0F, 8'hC8, 8'h38, 8'h07, 8'hA4
  };

  typedef struct packed {
    logic [OBJ_COORD_W-1:0] x;
    logic [OBJ_COORD_W-1:0] y;
    logic                   visible;
    logic                   blink;
  } obj_state_t;

endpackage

// File: rtl/multi_square_object_square_hit_test.sv
// Per-object rectangle containment test and offset computation, registered as pipeline stage 1.
module square_hit_test
  import multi_square_object_pkg::*;
#(
  parameter int COORD_W         = 11,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] objX,
  input  logic [COORD_W-1:0] objY,
  input  logic               shown,
  output logic               inside_p1,
  output logic [COORD_W-1:0] offsetX_p1,
  output logic [COORD_W-1:0] offsetY_p1
);

  localparam int SW = COORD_W + 1;

  // One extra bit keeps right/bottom edges from wrapping near the end of the coordinate range.
  logic [SW-1:0] px, py, left, top, right, bottom;
  logic          inside_c;

  assign px     = {1'b0, pixelX};
  assign py     = {1'b0, pixelY};
  assign left   = {1'b0, objX};
  assign top    = {1'b0, objY};
  assign right  = left + SW'(OBJECT_WIDTH_X);
  assign bottom = top + SW'(OBJECT_HEIGHT_Y);

  assign inside_c = shown && (px >= left) && (px < right) && (py >= top) && (py < bottom);

  // Stage 1 boundary
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_p1  <= 1'b0;
      offsetX_p1 <= '0;
      offsetY_p1 <= '0;
    end else begin
      inside_p1  <= inside_c;
      offsetX_p1 <= pixelX - objX;
      offsetY_p1 <= pixelY - objY;
    end
  end

endmodule

// File: rtl/multi_square_object.sv
// Up to 16 frame-synchronised rectangles with priority select; 2-cycle pixel-to-output latency.
// Optional blink gating and frame counter enabled by defining MULTI_SQUARE_OBJECT_BLINK_EN.
module multi_square_object
  import multi_square_object_pkg::*;
#(
  parameter  int NUM_OBJECTS       = 4,
  parameter  int OBJECT_WIDTH_X    = 32,
  parameter  int OBJECT_HEIGHT_Y   = 32,
  parameter  int COORD_W           = 11,
  parameter  int BLINK_HALF_FRAMES = 16,
  localparam int IDX_W             = (NUM_OBJECTS > 1) ? $clog2(NUM_OBJECTS) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               startOfFrame,
  input  logic               wrValid,
  output logic               wrReady,
  input  logic [IDX_W-1:0]   wrIdx,
  input  logic [COORD_W-1:0] wrTopLeftX,
  input  logic [COORD_W-1:0] wrTopLeftY,
  input  logic               wrVisible,
  input  logic               wrBlink,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic [IDX_W-1:0]   hitIndex,
  output logic               drawingRequest,
  output logic [7:0]         RGBout
);

  obj_state_t               shadow_q [NUM_OBJECTS];
  obj_state_t               active_q [NUM_OBJECTS];
  obj_state_t               wr_obj;
  logic [NUM_OBJECTS-1:0]   shown;
  logic [NUM_OBJECTS-1:0]   inside_p1;
  logic [COORD_W-1:0]       off_x_p1 [NUM_OBJECTS];
  logic [COORD_W-1:0]       off_y_p1 [NUM_OBJECTS];
  logic [NUM_OBJECTS-1:0]   unused_act;

  // The commit cycle blocks writes so shadow and active never update from the same edge.
  assign wrReady = resetN && !startOfFrame;

  always_comb begin
    wr_obj         = '0;
    wr_obj.x       = OBJ_COORD_W'(wrTopLeftX);
    wr_obj.y       = OBJ_COORD_W'(wrTopLeftY);
    wr_obj.visible = wrVisible;
`ifdef MULTI_SQUARE_OBJECT_BLINK_EN
    wr_obj.blink   = wrBlink;
`else
    wr_obj.blink   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OBJECTS; i++) begin
        if (wrValid && wrReady && (wrIdx == IDX_W'(i)))
          shadow_q[i] <= wr_obj;
        if (startOfFrame)
          active_q[i] <= shadow_q[i];
      end
    end
  end

`ifdef MULTI_SQUARE_OBJECT_BLINK_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      frame_cnt_q <= '0;
    else if (startOfFrame)
      frame_cnt_q <= (frame_cnt_q == 8'(2 * BLINK_HALF_FRAMES - 1)) ? 8'd0 : frame_cnt_q + 8'd1;
  end
`else
  logic unused_wr_blink;
  assign unused_wr_blink = wrBlink;
`endif

  for (genvar g = 0; g < NUM_OBJECTS; g++) begin : g_obj
`ifdef MULTI_SQUARE_OBJECT_BLINK_EN
    assign shown[g] = active_q[g].visible &&
                      (!active_q[g].blink || (frame_cnt_q < 8'(BLINK_HALF_FRAMES)));
`else
    assign shown[g] = active_q[g].visible;
`endif
    assign unused_act[g] = ^active_q[g];

    square_hit_test #(
      .COORD_W         (COORD_W),
      .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y)
    ) u_hit (
      .clk        (clk),
      .resetN     (resetN),
      .pixelX     (pixelX),
      .pixelY     (pixelY),
      .objX       (COORD_W'(active_q[g].x)),
      .objY       (COORD_W'(active_q[g].y)),
      .shown      (shown[g]),
      .inside_p1  (inside_p1[g]),
      .offsetX_p1 (off_x_p1[g]),
      .offsetY_p1 (off_y_p1[g])
    );
  end

  logic               hit_c;
  logic [IDX_W-1:0]   idx_c;
  logic [7:0]         rgb_c;
  logic [COORD_W-1:0] ox_c, oy_c;

  // Descending scan so the lowest set index is the last (winning) assignment.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    rgb_c = TRANSPARENT_ENCODING;
    ox_c  = '0;
    oy_c  = '0;
    for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
      if (inside_p1[i]) begin
        hit_c = 1'b1;
        idx_c = IDX_W'(i);
        rgb_c = COLOR_TABLE[i[3:0]];
        ox_c  = off_x_p1[i];
        oy_c  = off_y_p1[i];
      end
    end
  end

  // Stage 2 boundary
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      hitIndex       <= '0;
      RGBout         <= TRANSPARENT_ENCODING;
      offsetX        <= '0;
      offsetY        <= '0;
    end else begin
      drawingRequest <= hit_c;
      hitIndex       <= idx_c;
      RGBout         <= rgb_c;
      offsetX        <= ox_c;
      offsetY        <= oy_c;
    end
  end

endmodule

// File: tb/tb_multi_square_object.sv
// Self-checking bench for multi_square_object: vector table, directed corner sequences, random vs model.
module tb_multi_square_object;
  import multi_square_object_pkg::*;

  localparam int N   = 4;
  localparam int CW  = 11;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int BHF = 2;
  localparam int IW  = 2;
`ifdef MULTI_SQUARE_OBJECT_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic [CW-1:0] pixelX = '0, pixelY = '0;
  logic          startOfFrame = 1'b0;
  logic          wrValid = 1'b0;
  logic          wrReady;
  logic [IW-1:0] wrIdx = '0;
  logic [CW-1:0] wrTopLeftX = '0, wrTopLeftY = '0;
  logic          wrVisible = 1'b0, wrBlink = 1'b0;
  logic [CW-1:0] offsetX, offsetY;
  logic [IW-1:0] hitIndex;
  logic          drawingRequest;
  logic [7:0]    RGBout;

  multi_square_object #(
    .NUM_OBJECTS(N), .OBJECT_WIDTH_X(W), .OBJECT_HEIGHT_Y(H),
    .COORD_W(CW), .BLINK_HALF_FRAMES(BHF)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .wrValid(wrValid), .wrReady(wrReady),
    .wrIdx(wrIdx), .wrTopLeftX(wrTopLeftX), .wrTopLeftY(wrTopLeftY),
    .wrVisible(wrVisible), .wrBlink(wrBlink), .offsetX(offsetX), .offsetY(offsetY),
    .hitIndex(hitIndex), .drawingRequest(drawingRequest), .RGBout(RGBout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: what software wrote (shadow) and what the current frame shows (active).
  int sh_x [N], sh_y [N], act_x [N], act_y [N];
  bit sh_v [N], sh_b [N], act_v [N], act_b [N];
  int mcnt = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_v[i] = 0; sh_b[i] = 0;
      act_x[i] = 0; act_y[i] = 0; act_v[i] = 0; act_b[i] = 0;
    end
    mcnt = 0;
  endtask

  function automatic void model(input int px, input int py, output bit hit, output int idx,
                                output int ox, output int oy);
    bit shown;
    hit = 0; idx = 0; ox = 0; oy = 0;
    for (int i = 0; i < N; i++) begin
      shown = act_v[i] && (!BLINK_EN || !act_b[i] || (mcnt < BHF));
      if (!hit && shown && px >= act_x[i] && px < act_x[i] + W &&
          py >= act_y[i] && py < act_y[i] + H) begin
        hit = 1; idx = i; ox = px - act_x[i]; oy = py - act_y[i];
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_exp(input string name, input bit hit, input int idx, input int ox, input int oy);
    int rgb;
    rgb = hit ? int'(COLOR_TABLE[idx[3:0]]) : 255;
    chk({name, "_req"}, int'(drawingRequest), int'(hit));
    chk({name, "_idx"}, int'(hitIndex), hit ? idx : 0);
    chk({name, "_rgb"}, int'(RGBout), rgb);
    chk({name, "_ox"}, int'(offsetX), hit ? ox : 0);
    chk({name, "_oy"}, int'(offsetY), hit ? oy : 0);
  endtask

  task automatic probe(input string name, input int px, input int py);
    bit hit; int idx, ox, oy;
    pixelX = px[CW-1:0];
    pixelY = py[CW-1:0];
    tick();
    tick();
    model(px, py, hit, idx, ox, oy);
    check_exp(name, hit, idx, ox, oy);
  endtask

  task automatic do_write(input int idx, input int x, input int y, input bit v, input bit b);
    wrIdx = idx[IW-1:0]; wrTopLeftX = x[CW-1:0]; wrTopLeftY = y[CW-1:0];
    wrVisible = v; wrBlink = b; wrValid = 1'b1;
    tick();
    wrValid = 1'b0;
    sh_x[idx] = x; sh_y[idx] = y; sh_v[idx] = v; sh_b[idx] = b;
  endtask

  task automatic model_commit();
    for (int i = 0; i < N; i++) begin
      act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_v[i] = sh_v[i]; act_b[i] = sh_b[i];
    end
    mcnt = (mcnt + 1) % (2 * BHF);
  endtask

  task automatic commit();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    model_commit();
  endtask

  typedef struct {
    int px; int py; bit hit; int idx; int ox; int oy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    model_reset();
    tick();
    tick();
    check_exp("rst", 1'b0, 0, 0, 0);
    chk("rst_wrReady", int'(wrReady), 0);
    #2 resetN = 1'b1;
    #1 chk("rel_wrReady", int'(wrReady), 1);
    tick();

    // Scene: obj0 (10,20), obj1 (50,50), obj2 (20,30) overlapping obj0.
    do_write(0, 10, 20, 1, 0);
    do_write(1, 50, 50, 1, 0);
    do_write(2, 20, 30, 1, 0);
    commit();
    tbl[0] = '{10, 20, 1, 0, 0, 0};
    tbl[1] = '{42, 20, 0, 0, 0, 0};
    tbl[2] = '{41, 51, 1, 0, 31, 31};
    tbl[3] = '{30, 40, 1, 0, 20, 20};
    tbl[4] = '{45, 55, 1, 2, 25, 25};
    tbl[5] = '{60, 60, 1, 1, 10, 10};
    tbl[6] = '{9, 20, 0, 0, 0, 0};
    tbl[7] = '{81, 81, 1, 1, 31, 31};
    tbl[8] = '{82, 50, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      pixelX = tbl[i].px[CW-1:0];
      pixelY = tbl[i].py[CW-1:0];
      tick();
      tick();
      check_exp($sformatf("tbl%0d", i), tbl[i].hit, tbl[i].idx, tbl[i].ox, tbl[i].oy);
    end

    // Priority between coincident objects, then hiding the winner.
    do_write(0, 50, 50, 1, 0);
    commit();
    probe("prio_both", 60, 60);
    chk("prio_idx0", int'(hitIndex), 0);
    do_write(0, 50, 50, 0, 0);
    commit();
    probe("prio_hidden", 60, 60);
    chk("prio_idx1", int'(hitIndex), 1);
    chk("prio_off", int'(offsetX), 10);

    // Mid-frame write stays invisible until the next commit.
    do_write(2, 100, 100, 1, 0);
    probe("midframe", 100, 100);
    chk("midframe_miss", int'(drawingRequest), 0);
    commit();
    probe("after_commit", 100, 100);
    chk("after_commit_hit", int'(drawingRequest), 1);

    // Write presented during the commit cycle is stalled one cycle.
    startOfFrame = 1'b1;
    wrIdx = 2'd3; wrTopLeftX = 11'd200; wrTopLeftY = 11'd200;
    wrVisible = 1'b1; wrBlink = 1'b0; wrValid = 1'b1;
    #1 chk("sof_wrReady", int'(wrReady), 0);
    tick();
    model_commit();
    startOfFrame = 1'b0;
    #1 chk("post_sof_wrReady", int'(wrReady), 1);
    tick();
    wrValid = 1'b0;
    sh_x[3] = 200; sh_y[3] = 200; sh_v[3] = 1; sh_b[3] = 0;
    probe("stall_pending", 200, 200);
    chk("stall_pending_miss", int'(drawingRequest), 0);
    commit();
    probe("stall_done", 200, 200);
    chk("stall_done_idx", int'(hitIndex), 3);

    // Blink over several frames (with gating disabled, always shown).
    do_write(3, 300, 300, 1, 1);
    commit();
    for (int f = 0; f < 6; f++) begin
      probe($sformatf("blink_f%0d", mcnt), 305, 305);
      if (BLINK_EN)
        chk($sformatf("blink_shown_f%0d", mcnt), int'(drawingRequest), (mcnt < BHF) ? 1 : 0);
      else
        chk($sformatf("noblink_shown_%0d", f), int'(drawingRequest), 1);
      commit();
    end

    // Right-edge object must not wrap into small X.
    do_write(0, 2040, 0, 1, 0);
    commit();
    probe("edge_wrap", 5, 0);
    chk("edge_wrap_miss", int'(drawingRequest), 0);
    probe("edge_in", 2047, 5);

    // Randomised writes, commits and pixels.
    for (int n = 0; n < 150; n++) begin
      int r, k, px, py;
      r = int'($urandom_range(0, 9));
      if (r < 3)
        do_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 300)),
                 int'($urandom_range(0, 300)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      else if (r == 3)
        commit();
      k = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 1) == 1) begin
        px = act_x[k] + int'($urandom_range(0, 40)) - 4;
        py = act_y[k] + int'($urandom_range(0, 40)) - 4;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        if (px > 2047) px = 2047;
        if (py > 2047) py = 2047;
      end else begin
        px = int'($urandom_range(0, 400));
        py = int'($urandom_range(0, 400));
      end
      probe($sformatf("rnd%0d", n), px, py);
    end

    // Asynchronous reset mid-frame with a write pending.
    do_write(1, 50, 50, 1, 0);
    commit();
    probe("pre_reset", 60, 60);
    wrIdx = 2'd2; wrTopLeftX = 11'd0; wrTopLeftY = 11'd0;
    wrVisible = 1'b1; wrValid = 1'b1;
    #2 resetN = 1'b0;
    #1 check_exp("async_rst", 1'b0, 0, 0, 0);
    chk("async_rst_wrReady", int'(wrReady), 0);
    tick();
    wrValid = 1'b0;
    #2 resetN = 1'b1;
    #1 chk("rerel_wrReady", int'(wrReady), 1);
    model_reset();
    probe("post_rst_old", 60, 60);
    probe("post_rst_origin", 0, 0);
    commit();
    probe("post_rst_commit", 0, 0);
    chk("post_rst_no_obj", int'(drawingRequest), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
